// File: rtl/cache_controller.sv
// Cache controller: blocking CPU-side FSM for a set-associative array.
// It resolves hits, writes back dirty victims and refills lines from memory
// over a per-beat req/ack handshake.
module cache_controller #(
   parameter int ADDRESS_WORD_SIZE = 32,
   parameter int TAG_SIZE          = 19,
   parameter int WORD_SIZE         = 8,
   parameter int BLOCK_SIZE        = 8
) (
   input  logic                         clk,
   input  logic                         rst_b,
   // CPU port
   input  logic                         cpu_req,
   input  logic                         cpu_we,
   input  logic [ADDRESS_WORD_SIZE-1:0] cpu_addr,
   input  logic [WORD_SIZE-1:0]         cpu_wdata,
   output logic                         cpu_ready,
   output logic                         cpu_done,
   output logic [WORD_SIZE-1:0]         cpu_rdata,
   // cache array port
   output logic [ADDRESS_WORD_SIZE-1:0] cache_addr,
   output logic                         try_read,
   output logic                         try_write,
   output logic                         cache_write,
   output logic [WORD_SIZE-1:0]         cache_wdata,
   input  logic [WORD_SIZE-1:0]         cache_rdata,
   input  logic                         cache_hit,
   input  logic                         cache_dirty,
   input  logic [TAG_SIZE-1:0]          cache_victim_tag,
   // memory port
   output logic                         mem_req,
   output logic                         mem_we,
   output logic [ADDRESS_WORD_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0]         mem_wdata,
   input  logic [WORD_SIZE-1:0]         mem_rdata,
   input  logic                         mem_ack
);

   localparam int OFF_W  = 6;
   localparam int IDX_W  = ADDRESS_WORD_SIZE - TAG_SIZE - OFF_W;
   localparam int CNT_W  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int STRIDE = 64 / BLOCK_SIZE;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_SIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_WRITE, S_WB, S_REFILL, S_DONE
   } state_t;

   state_t                         state_q, state_d;
   logic                           we_q, we_d;
   logic [ADDRESS_WORD_SIZE-1:0]   addr_q, addr_d;
   logic [WORD_SIZE-1:0]           wdata_q, wdata_d;
   logic [WORD_SIZE-1:0]           rdata_q, rdata_d;
   logic [TAG_SIZE-1:0]            victim_tag_q, victim_tag_d;
   logic [CNT_W-1:0]               beat_q, beat_d;

   logic [OFF_W-1:0]               beat_off;
   logic [ADDRESS_WORD_SIZE-1:0]   wb_addr;
   logic [ADDRESS_WORD_SIZE-1:0]   rf_addr;
   logic                           last_ack;

   // Line base has a zero offset, so the beat offset is simply concatenated.
   assign beat_off  = OFF_W'(int'(beat_q) * STRIDE);
   assign wb_addr   = {victim_tag_q, addr_q[OFF_W +: IDX_W], beat_off};
   assign rf_addr   = {addr_q[ADDRESS_WORD_SIZE-1 -: TAG_SIZE], addr_q[OFF_W +: IDX_W], beat_off};
   assign last_ack  = mem_ack && (beat_q == LAST_BEAT);
   assign cpu_rdata = rdata_q;

   // State and request latches; reset returns everything to an idle, empty controller.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         victim_tag_q <= '0;
         beat_q       <= '0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         victim_tag_q <= victim_tag_d;
         beat_q       <= beat_d;
      end
   end

   // Next-state selection; a miss branches on the victim's dirty flag directly.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (cpu_req) state_d = S_LOOKUP;
         S_LOOKUP: begin
            if (cache_hit) state_d = we_q ? S_WRITE : S_DONE;
            else           state_d = cache_dirty ? S_WB : S_REFILL;
         end
         S_WRITE:  state_d = S_DONE;
         S_WB:     if (last_ack) state_d = S_REFILL;
         S_REFILL: if (last_ack) state_d = S_LOOKUP;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Request capture, load result capture, victim tag and beat counter updates.
   always_comb begin
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      victim_tag_d = victim_tag_q;
      beat_d       = beat_q;
      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               we_d    = cpu_we;
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
            end
         end
         S_LOOKUP: begin
            if (cache_hit) begin
               if (!we_q) rdata_d = cache_rdata;
            end else begin
               victim_tag_d = cache_victim_tag;
               beat_d       = '0;
            end
         end
         S_WB, S_REFILL: begin
            if (mem_ack) beat_d = last_ack ? '0 : beat_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   // Moore-style outputs, except the refill write strobe which follows mem_ack.
   always_comb begin
      cpu_ready   = 1'b0;
      cpu_done    = 1'b0;
      cache_addr  = addr_q;
      try_read    = 1'b0;
      try_write   = 1'b0;
      cache_write = 1'b0;
      cache_wdata = '0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      case (state_q)
         S_IDLE:   cpu_ready = 1'b1;
         S_LOOKUP: try_read  = 1'b1;
         S_WRITE: begin
            try_write   = 1'b1;
            cache_wdata = wdata_q;
         end
         S_WB: begin
            cache_addr = wb_addr;
            try_read   = 1'b1;
            mem_req    = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = wb_addr;
            mem_wdata  = cache_rdata;
         end
         S_REFILL: begin
            mem_req  = 1'b1;
            mem_addr = rf_addr;
            if (mem_ack) begin
               cache_write = 1'b1;
               cache_addr  = rf_addr;
               cache_wdata = mem_rdata;
            end
         end
         S_DONE:   cpu_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_controller.sv
// Testbench for cache_controller: behavioural cache array and memory models,
// directed requests with hand-computed expectations checked by a scoreboard.
module tb_cache_controller;

   logic        clk;
   logic        rst_b;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ready, cpu_done;
   logic [7:0]  cpu_rdata;
   logic [31:0] cache_addr;
   logic        try_read, try_write, cache_write;
   logic [7:0]  cache_wdata, cache_rdata;
   logic        cache_hit, cache_dirty;
   logic [18:0] cache_victim_tag;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        mem_ack;

   cache_controller dut (
      .clk(clk), .rst_b(rst_b),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .cache_addr(cache_addr), .try_read(try_read), .try_write(try_write),
      .cache_write(cache_write), .cache_wdata(cache_wdata), .cache_rdata(cache_rdata),
      .cache_hit(cache_hit), .cache_dirty(cache_dirty), .cache_victim_tag(cache_victim_tag),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   function automatic void chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
   endfunction

   always @(posedge clk) cyc++;

   // ---------------- cache array model ----------------
   bit [18:0] ctag   [128];
   bit        cvalid [128];
   bit        cdirty [128];
   bit [7:0]  cdata  [128][8];

   logic       pl_en = 1'b0;
   logic [6:0] pl_idx;
   logic [18:0] pl_tag;
   logic       pl_dirty;
   logic [7:0] pl_base;

   assign cache_rdata      = cdata[cache_addr[12:6]][cache_addr[5:3]];
   assign cache_hit        = cvalid[cache_addr[12:6]] && (ctag[cache_addr[12:6]] == cache_addr[31:13]);
   assign cache_dirty      = cdirty[cache_addr[12:6]];
   assign cache_victim_tag = ctag[cache_addr[12:6]];

   always @(posedge clk) begin
      if (pl_en) begin
         ctag[pl_idx]   <= pl_tag;
         cvalid[pl_idx] <= 1'b1;
         cdirty[pl_idx] <= pl_dirty;
         for (int k = 0; k < 8; k++) cdata[pl_idx][k] <= pl_base + 8'(k);
      end else if (cache_write) begin
         cdata[cache_addr[12:6]][cache_addr[5:3]] <= cache_wdata;
         ctag[cache_addr[12:6]]   <= cache_addr[31:13];
         cvalid[cache_addr[12:6]] <= 1'b1;
         cdirty[cache_addr[12:6]] <= 1'b0;
      end else if (try_write) begin
         cdata[cache_addr[12:6]][cache_addr[5:3]] <= cache_wdata;
         cdirty[cache_addr[12:6]] <= 1'b1;
      end
   end

   task automatic preload(input logic [6:0] idx, input logic [18:0] tag, input logic dirty,
                          input logic [7:0] base);
      pl_idx = idx; pl_tag = tag; pl_dirty = dirty; pl_base = base;
      @(posedge clk); #1 pl_en = 1'b1;
      @(posedge clk); #1 pl_en = 1'b0;
   endtask

   // ---------------- memory model with expected-beat queue ----------------
   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [7:0]  data;
   } beat_t;

   beat_t bq[$];
   int    wait_n    = 0;
   int    wcnt      = 0;
   int    mem_beats = 0;

   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
   end

   always @(negedge clk) begin
      if (rst_b) begin
         mem_ack = 1'b0;
         wcnt    = 0;
      end else if (mem_req) begin
         if (bq.size() == 0) begin
            chk("mem_unexpected_beat", mem_addr, 32'hFFFF_FFFF);
            mem_ack   = 1'b1;
            mem_rdata = 8'h00;
            mem_beats++;
         end else begin
            chk("mem_addr", mem_addr, bq[0].addr);
            chk("mem_we", mem_we, bq[0].we);
            if (bq[0].we) chk("mem_wdata", mem_wdata, bq[0].data);
            if (wcnt < wait_n) begin
               wcnt++;
               mem_ack = 1'b0;
            end else begin
               wcnt      = 0;
               mem_ack   = 1'b1;
               mem_rdata = bq[0].we ? 8'h00 : bq[0].data;
               void'(bq.pop_front());
               mem_beats++;
            end
         end
      end else begin
         mem_ack = 1'b0;
      end
   end

   task automatic push_burst(input logic [31:0] base, input logic we, input logic [7:0] dbase);
      beat_t b;
      for (int k = 0; k < 8; k++) begin
         b.addr = base + 32'(8 * k);
         b.we   = we;
         b.data = dbase + 8'(k);
         bq.push_back(b);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      int         lat;
      bit         is_load;
      logic [7:0] rdata;
      int         tw;
      int         nb;
   } exp_t;

   exp_t  sb[$];
   string sb_nm[$];
   int    accept_cyc   = 0;
   int    accept_beats = 0;
   int    tw_cnt       = 0;
   int    tw_at        = 0;
   int    done_cnt     = 0;
   int    strobe_viol  = 0;

   always @(negedge clk) begin
      if (!$onehot0({try_read, try_write, cache_write})) strobe_viol++;
      if (!rst_b) begin
         if (cpu_req && cpu_ready) begin
            accept_cyc   = cyc;
            accept_beats = mem_beats;
            tw_cnt       = 0;
         end
         if (try_write) begin
            tw_cnt++;
            tw_at = cyc - accept_cyc;
         end
         if (cpu_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t  e;
               string nm;
               int    tw_act;
               e  = sb.pop_front();
               nm = sb_nm.pop_front();
               tw_act = (tw_cnt == 0) ? -1 : ((tw_cnt == 1) ? tw_at : 1000 + tw_cnt);
               chk({nm, "_latency"}, cyc - accept_cyc, e.lat);
               if (e.is_load) chk({nm, "_rdata"}, cpu_rdata, e.rdata);
               chk({nm, "_try_write_cycle"}, tw_act, e.tw);
               chk({nm, "_mem_beats"}, mem_beats - accept_beats, e.nb);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_req(input logic we, input logic [31:0] a, input logic [7:0] wd,
                         input logic [7:0] rd, input int lat, input int tw, input int nb,
                         input string nm);
      exp_t e;
      int   t;
      int   start;
      e.lat = lat; e.is_load = !we; e.rdata = rd; e.tw = tw; e.nb = nb;
      sb.push_back(e);
      sb_nm.push_back(nm);
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      t = 0;
      while (!cpu_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      start = done_cnt;
      @(posedge clk); #1;
      // Scrambled inputs with cpu_req still high while busy must be ignored.
      cpu_we = ~we; cpu_addr = a ^ 32'hFFFF_FFC0; cpu_wdata = ~wd;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      t = 0;
      while (done_cnt == start && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (done_cnt == start) begin
         chk({nm, "_timeout"}, 0, 1);
         sb.delete();
         sb_nm.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      int start_done;
      int start_beats;
      rst_b = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cpu_ready", cpu_ready, 1);
      chk("rst_cpu_done", cpu_done, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_strobes", {try_read, try_write, cache_write}, 0);
      rst_b = 1'b0;

      // Read hit and store hit on line 0x2040 (tag 1, index 1).
      preload(7'd1, 19'd1, 1'b0, 8'h5A);
      do_req(1'b0, 32'h0000_2040, 8'h00, 8'h5A, 2, -1, 0, "read_hit");
      do_req(1'b1, 32'h0000_2040, 8'hC3, 8'h00, 3, 2, 0, "store_hit");
      do_req(1'b0, 32'h0000_2040, 8'h00, 8'hC3, 2, -1, 0, "read_after_store");

      // Clean read miss, zero-wait memory.
      push_burst(32'h0001_0080, 1'b0, 8'h10);
      do_req(1'b0, 32'h0001_0080, 8'h00, 8'h10, 11, -1, 8, "clean_miss");

      // Dirty miss: victim tag 2 at index 2, store to tag 5.
      preload(7'd2, 19'd2, 1'b1, 8'hB0);
      push_burst(32'h0000_4080, 1'b1, 8'hB0);
      push_burst(32'h0000_A080, 1'b0, 8'h20);
      do_req(1'b1, 32'h0000_A088, 8'h77, 8'h00, 20, 19, 16, "dirty_store_miss");
      do_req(1'b0, 32'h0000_A088, 8'h00, 8'h77, 2, -1, 0, "read_stored_word");
      do_req(1'b0, 32'h0000_A090, 8'h00, 8'h22, 2, -1, 0, "read_refilled_word");

      // Dirty load miss with three wait states per beat on both bursts.
      preload(7'd6, 19'd3, 1'b1, 8'hD0);
      push_burst(32'h0000_6180, 1'b1, 8'hD0);
      push_burst(32'h0000_0180, 1'b0, 8'h40);
      wait_n = 3;
      do_req(1'b0, 32'h0000_0190, 8'h00, 8'h42, 67, -1, 16, "wait_state_miss");
      wait_n = 0;

      // Reset asserted while the refill sits at beat 4.
      push_burst(32'h0000_0140, 1'b0, 8'h60);
      start_beats = mem_beats;
      start_done  = done_cnt;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0140;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      t = 0;
      while ((mem_beats - start_beats) < 4 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("midburst_reach_beat4", mem_beats - start_beats, 4);
      @(posedge clk); #1;
      rst_b = 1'b1;
      #1;
      chk("midburst_rst_mem_req", mem_req, 0);
      chk("midburst_rst_cpu_ready", cpu_ready, 1);
      chk("midburst_rst_strobes", {try_read, try_write, cache_write}, 0);
      chk("midburst_rst_rdata", cpu_rdata, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_b = 1'b0;
      bq.delete();
      repeat (3) @(negedge clk);
      chk("midburst_no_done", done_cnt - start_done, 0);
      do_req(1'b0, 32'h0000_2040, 8'h00, 8'hC3, 2, -1, 0, "after_reset_read");

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      chk("beats_drained", bq.size(), 0);
      chk("strobe_onehot", strobe_viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cache_controller.md
# cache_controller

Control FSM that sits between the CPU load/store port and the set-associative cache array, acting as the initiator that drives the array's `try_read`/`try_write`/`cache_write` strobes. It handles hits, write-back of dirty victims, and line refill from main memory over a per-beat req/ack handshake. Processing is blocking: the controller accepts one CPU request at a time and completes it before accepting the next.

## Interface
- `ADDRESS_WORD_SIZE`, 32, address width.
- `TAG_SIZE`, 19, tag width (`addr[31:13]`); index is `addr[12:6]`, and the line offset is `addr[5:0]`.
- `WORD_SIZE`, 8, data word width.
- `BLOCK_SIZE`, 8, beats per line. The beat stride is 64/`BLOCK_SIZE` = 8 bytes.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_b`  in  1  asynchronous, active-high reset: 1 resets, despite the suffix.
- `cpu_req`  in  1  request valid.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  ADDRESS_WORD_SIZE  request address.
- `cpu_wdata`  in  WORD_SIZE  store data.
- `cpu_ready`  out  1  high only in IDLE; a request is accepted when `cpu_req & cpu_ready`.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  WORD_SIZE  load result; held until the next load completes.
- `cache_addr`  out  ADDRESS_WORD_SIZE  address to the array.
- `try_read`, `try_write`, `cache_write`  out  1 each  array strobes.
- `cache_wdata`  out  WORD_SIZE  array write data.
- `cache_rdata`  in  WORD_SIZE  array data, combinational from `cache_addr`.
- `cache_hit`, `cache_dirty`  in  1 each  array hit, and victim-dirty flag.
- `cache_victim_tag`  in  TAG_SIZE  tag of the line that will be replaced on a miss.
- `mem_req`, `mem_we`  out  1 each  memory beat request and direction.
- `mem_addr`  out  ADDRESS_WORD_SIZE  beat address.
- `mem_wdata`  out  WORD_SIZE  write-back data.
- `mem_rdata`  in  WORD_SIZE  refill data, valid while `mem_ack` is high.
- `mem_ack`  in  1  beat complete.

## Operation
- **States:** IDLE, LOOKUP, WRITE, WB, REFILL, DONE.
- **IDLE:** `cpu_ready`=1. On accept, latch `cpu_we`, `cpu_addr` and `cpu_wdata`, then go to LOOKUP.
- **LOOKUP:** `cache_addr` = latched address, `try_read`=1. Outcomes:
  - Hit on a load: capture `cache_rdata` into `cpu_rdata`, go to DONE.
  - Hit on a store: go to WRITE.
  - Miss: latch `cache_dirty` and `cache_victim_tag`, clear the beat counter, go to WB if dirty, else REFILL.
- **WRITE:** `try_write`=1 and `cache_wdata` = latched data for one cycle, then DONE.
- **WB:** `cache_addr` = {victim_tag, index, 6'b0} + 8·k, with `try_read`=1.
  - `mem_req`=1, `mem_we`=1, `mem_addr` = the same address, `mem_wdata` = `cache_rdata`.
  - Each `mem_ack` increments k. The ack with k = BLOCK_SIZE−1 clears k and moves to REFILL.
- **REFILL:** `mem_req`=1, `mem_we`=0, `mem_addr` = {req tag, index, 6'b0} + 8·k.
  - When `mem_ack`=1: `cache_write`=1 combinationally that cycle, `cache_addr` = `mem_addr`, `cache_wdata` = `mem_rdata`.
  - The last ack goes to LOOKUP. That re-lookup must hit; a store is then performed by WRITE.
- **DONE:** `cpu_done`=1 for one cycle, then IDLE.
- **Strobes:** at most one of `try_read`/`try_write`/`cache_write` is high in any cycle. Exception: WB uses `try_read` only.
- **Handshake:** `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req`=1 and `mem_ack`=0. `mem_ack` is ignored when `mem_req`=0.
- **Beat counter:** width is log2(BLOCK_SIZE). Wrap to 0 happens only at block end.
- **Request inputs:** `cpu_req` is ignored outside IDLE. CPU inputs that change after accept have no effect.

## Timing
- **Reset values:** state IDLE, `cpu_ready`=1, `cpu_done`=0, `cpu_rdata`=0, `mem_req`=0, all strobes 0, beat counter 0, latches 0.
- **Reset mid-transaction:** `rst_b`=1 at any point, including mid-burst, immediately drops `mem_req` and strobes. No completion pulse is issued.
- **Latency, counted from the accept edge (cycle 0):**
  - Load hit: `cpu_done` in cycle 2.
  - Store hit: `cpu_done` in cycle 3.
  - Clean load miss with zero-wait memory: REFILL cycles 2–9, LOOKUP 10, `cpu_done` 11.
  - Dirty miss: adds BLOCK_SIZE cycles plus memory wait states.
- **Throughput:** the next accept is possible in the cycle after DONE. `cpu_ready` goes high the cycle after `cpu_done`.

## Test plan
- **Read hit:** preload line at 0x0000_2040 with 0x5A, load 0x0000_2040 → `cpu_done` at cycle 2, `cpu_rdata`=0x5A, no `mem_req`.
- **Store hit:** store 0xC3 to 0x0000_2040 → `try_write` high exactly one cycle (cycle 2), `cpu_done` at cycle 3, and a subsequent load returns 0xC3.
- **Clean read miss:** load 0x0001_0080, memory acks every cycle with data 0x10+k → 8 reads at 0x0001_0080 + 8k, then `cpu_done` at cycle 11 with `cpu_rdata`=0x10.
- **Dirty miss:** victim tag 0x00002 at index 2, miss on tag 0x00005 → 8 write beats at 0x0000_4080 + 8k carrying victim data, then 8 read beats at 0x0000_A080 + 8k, then a store commits.
- **Wait states:** hold `mem_ack` low 3 cycles per beat → `mem_addr` and `mem_wdata` stay stable, k advances only on ack, and total latency grows by 24 cycles per burst.
- **Reset mid-burst:** assert `rst_b` at REFILL beat 4 → `mem_req`=0 immediately, `cpu_ready`=1, no `cpu_done`, and the next request proceeds normally.
